// File: rtl/ifmap_row_framer_pkg.sv
// Shared definitions for the ifmap row framer: FSM states, tag bit
// positions inside the pushed word, and skid FIFO sizing.
package ifmap_framer_pkg;

  localparam int PKG_DATA_WIDTH = 16;
  localparam int PKG_ADDR_WIDTH = 10;
  localparam int PKG_LEN_WIDTH  = 8;

  // Tag positions within {start_bit, end_bit, data}
  localparam int START_BIT = PKG_DATA_WIDTH + 1;
  localparam int END_BIT   = PKG_DATA_WIDTH;

  // Two entries cover the one-cycle SRAM latency plus one stalled word
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ifmap_row_framer_if.sv
// SRAM read port and ifmap buffer push port of the row framer.
// master = framer side, slave = SRAM/buffer side.
interface ifmap_row_framer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic                    buf_full;
  logic                    buf_write_en;
  logic [DATA_WIDTH+1:0]   buf_data;

  modport master (
    output mem_rd_en, mem_addr, buf_write_en, buf_data,
    input  mem_rd_data, buf_full
  );

  modport slave (
    input  mem_rd_en, mem_addr, buf_write_en, buf_data,
    output mem_rd_data, buf_full
  );
endinterface

// File: rtl/ifmap_row_framer_skid_fifo.sv
// Two-entry register FIFO that absorbs SRAM words while the ifmap
// buffer is full. The caller guarantees no push when full and no pop
// when empty.
module framer_skid_fifo
  import ifmap_framer_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_r [SKID_DEPTH];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [SKID_CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; reset clears contents so head reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= {WIDTH{1'b0}};
      mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= {SKID_CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/ifmap_row_framer.sv
// Fetches a 2-D ifmap window row by row from a 1-cycle-latency SRAM,
// tags each word with start/end-of-row bits and pushes
// {start_bit, end_bit, data} into the PE's ifmap buffer, throttling on
// buf_full through a two-entry skid FIFO.
module ifmap_row_framer
  import ifmap_framer_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH,
  parameter int LEN_WIDTH  = PKG_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
  input  logic [ADDR_WIDTH-1:0] row_pitch,
  ifmap_row_framer_if.master    bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};

  state_e                  state_r;
  state_e                  next_state_s;

  logic [ADDR_WIDTH-1:0]   row_base_r;
  logic [ADDR_WIDTH-1:0]   row_pitch_r;
  logic [LEN_WIDTH-1:0]    col_r;
  logic [LEN_WIDTH-1:0]    row_r;
  logic [LEN_WIDTH-1:0]    row_len_r;
  logic [LEN_WIDTH-1:0]    num_rows_r;

  logic                    inflight_r;
  logic                    inflight_start_r;
  logic                    inflight_end_r;

  logic [SKID_CNT_W-1:0]   count_s;
  logic [DATA_WIDTH+1:0]   head_s;
  logic [DATA_WIDTH+1:0]   fifo_din_s;
  logic [2:0]              occ_s;

  logic                    push_s;
  logic                    rd_en_s;
  logic                    col_last_s;
  logic                    row_last_s;
  logic                    last_rd_s;
  logic                    drain_done_s;
  logic                    zero_cmd_s;
  logic [ADDR_WIDTH-1:0]   addr_s;

  assign col_last_s = (col_r == (row_len_r - LEN_ONE));
  assign row_last_s = (row_r == (num_rows_r - LEN_ONE));
  assign zero_cmd_s = (row_len == LEN_ZERO) || (num_rows == LEN_ZERO);
  assign occ_s      = {1'b0, count_s} + {2'b00, inflight_r};
  assign addr_s     = row_base_r + ADDR_WIDTH'(col_r);
  assign fifo_din_s = {inflight_start_r, inflight_end_r, bus.mem_rd_data};

  framer_skid_fifo #(
    .WIDTH (DATA_WIDTH + 2)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_r),
    .pop   (push_s),
    .din   (fifo_din_s),
    .head  (head_s),
    .count (count_s)
  );

  // Push/read decisions: a read is issued only if the skid FIFO can take it
  always_comb begin
    push_s       = 1'b0;
    rd_en_s      = 1'b0;
    last_rd_s    = 1'b0;
    drain_done_s = 1'b0;
    if ((count_s != {SKID_CNT_W{1'b0}}) && !bus.buf_full) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((state_r == FETCH) && (occ_s <= (3'd1 + {2'b00, push_s}))) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    last_rd_s = rd_en_s && col_last_s && row_last_s;
    if (!inflight_r &&
        ((count_s == {SKID_CNT_W{1'b0}}) ||
         ((count_s == SKID_CNT_W'(1)) && push_s))) begin
      drain_done_s = 1'b1;
    end else begin
      drain_done_s = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = zero_cmd_s ? DONE : FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        if (last_rd_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = FETCH;
        end
      end
      DRAIN: begin
        if (drain_done_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = DRAIN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Command capture and row/column address counters
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_r  <= {ADDR_WIDTH{1'b0}};
      row_pitch_r <= {ADDR_WIDTH{1'b0}};
      col_r       <= LEN_ZERO;
      row_r       <= LEN_ZERO;
      row_len_r   <= LEN_ZERO;
      num_rows_r  <= LEN_ZERO;
    end else if ((state_r == IDLE) && start) begin
      row_base_r  <= base_addr;
      row_pitch_r <= row_pitch;
      col_r       <= LEN_ZERO;
      row_r       <= LEN_ZERO;
      row_len_r   <= row_len;
      num_rows_r  <= num_rows;
    end else if (rd_en_s) begin
      if (col_last_s) begin
        col_r      <= LEN_ZERO;
        row_r      <= row_r + LEN_ONE;
        row_base_r <= row_base_r + row_pitch_r;
      end else begin
        col_r      <= col_r + LEN_ONE;
      end
    end
  end

  // Tags travel alongside the outstanding SRAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r       <= 1'b0;
      inflight_start_r <= 1'b0;
      inflight_end_r   <= 1'b0;
    end else begin
      inflight_r       <= rd_en_s;
      inflight_start_r <= (col_r == LEN_ZERO);
      inflight_end_r   <= col_last_s;
    end
  end

  assign bus.mem_rd_en    = rd_en_s;
  assign bus.mem_addr     = rd_en_s ? addr_s : {ADDR_WIDTH{1'b0}};
  assign bus.buf_write_en = push_s;
  assign bus.buf_data     = head_s;
  assign busy             = (state_r != IDLE);
  assign done             = (state_r == DONE);

endmodule

// File: tb/tb_ifmap_row_framer.sv
// Scoreboard bench for ifmap_row_framer: expected pushes and addresses
// are queued by the stimulus, a negedge monitor pops and compares them.
module tb_ifmap_row_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] base_addr;
  logic [7:0] row_len;
  logic [7:0] num_rows;
  logic [9:0] row_pitch;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  ifmap_row_framer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus ();

  ifmap_row_framer #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_len   (row_len),
    .num_rows  (num_rows),
    .row_pitch (row_pitch),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  logic [15:0] mem_model [1024];
  logic [17:0] exp_q [$];
  logic [9:0]  addr_q [$];

  logic [17:0] job1_exp [12] = '{
    18'h2000E, 18'h00027, 18'h000A4, 18'h000AB, 18'h0FFFA, 18'h1FFB0,
    18'h2007A, 18'h00009, 18'h0009B, 18'h0FFCD, 18'h0FFE6, 18'h10093
  };
  logic [15:0] job1_mem [12] = '{
    16'h000E, 16'h0027, 16'h00A4, 16'h00AB, 16'hFFFA, 16'hFFB0,
    16'h007A, 16'h0009, 16'h009B, 16'hFFCD, 16'hFFE6, 16'h0093
  };

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;
  int done_rel, first_rel, pushes, reads, reads_full;

  // Synchronous SRAM model with one-cycle read latency
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mem_model[bus.mem_addr] : 16'h0000;
  end

  // Free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every push and address against the scoreboard
  always @(negedge clk) begin
    if (bus.buf_write_en) begin
      pushes++;
      if (first_rel < 0) first_rel = cyc - c0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got %h expected no push", bus.buf_data);
      end else begin
        check("push_data", {14'h0, bus.buf_data}, {14'h0, exp_q.pop_front()});
      end
    end
    if (bus.mem_rd_en) begin
      reads++;
      if (bus.buf_full) reads_full++;
      if (addr_q.size() != 0) check("mem_addr", {22'h0, bus.mem_addr}, {22'h0, addr_q.pop_front()});
    end
    if (done) done_rel = cyc - c0;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    done_rel = -1; first_rel = -1; pushes = 0; reads = 0; reads_full = 0;
  endtask

  task automatic run_job(input logic [9:0] base, input logic [7:0] len, input logic [7:0] rows,
                         input logic [9:0] pitch, input int exp_done, input int exp_pushes,
                         input int full_at, input int full_len, input int ign_at);
    base_addr = base; row_len = len; num_rows = rows; row_pitch = pitch;
    clear_stats();
    c0 = cyc;
    start = 1'b1;
    for (int k = 1; k < 200; k++) begin
      next_cyc();
      if (k == 1) begin
        start = 1'b0;
        base_addr = 10'h155; row_len = 8'd9; num_rows = 8'd9; row_pitch = 10'h0AA;
      end
      if (k == ign_at) start = 1'b1;
      if (k == ign_at + 1) start = 1'b0;
      if (k == full_at) bus.buf_full = 1'b1;
      if (k == full_at + full_len) bus.buf_full = 1'b0;
      if (done_rel >= 0 && k > done_rel + 1) break;
    end
    check("done_cycle", done_rel, exp_done);
    check("push_count", pushes, exp_pushes);
    check("read_count", reads, exp_pushes);
    check("scoreboard_empty", exp_q.size(), 0);
    check("addr_queue_empty", addr_q.size(), 0);
    check("idle_after_job", {31'h0, busy}, 32'h0);
    if (exp_pushes > 0) check("first_push_cycle", first_rel, 3);
    if (full_at > 0) check("reads_while_full_le2", {31'h0, (reads_full <= 2)}, 32'h1);
  endtask

  task automatic queue_job1();
    for (int i = 0; i < 12; i++) exp_q.push_back(job1_exp[i]);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_model[i] = 16'h0000;
    for (int i = 0; i < 12; i++) mem_model[i] = job1_mem[i];
    mem_model[10'h020] = 16'h1234;
    mem_model[10'h025] = 16'h8001;
    mem_model[10'h02A] = 16'hFFFF;
    mem_model[10'h3FE] = 16'hAAAA;
    mem_model[10'h3FF] = 16'h5555;
    clear_stats();

    rst = 1'b1; start = 1'b0; bus.buf_full = 1'b0;
    base_addr = 10'h0; row_len = 8'd0; num_rows = 8'd0; row_pitch = 10'h0;
    next_cyc(); next_cyc();
    @(negedge clk);
    check("rst_mem_rd_en", {31'h0, bus.mem_rd_en}, 32'h0);
    check("rst_mem_addr", {22'h0, bus.mem_addr}, 32'h0);
    check("rst_buf_write_en", {31'h0, bus.buf_write_en}, 32'h0);
    check("rst_buf_data", {14'h0, bus.buf_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    next_cyc();

    // 2x6 window, no back-pressure
    queue_job1();
    run_job(10'h000, 8'd6, 8'd3 - 8'd1, 10'd6, 15, 12, -1, 0, -1);

    // single-element rows, with a start pulse while busy
    exp_q.push_back(18'h31234); exp_q.push_back(18'h38001); exp_q.push_back(18'h3FFFF);
    run_job(10'h020, 8'd1, 8'd3, 10'd5, 6, 3, -1, 0, 2);

    // same 12-word job with buf_full high for cycles 5..9
    queue_job1();
    run_job(10'h000, 8'd6, 8'd2, 10'd6, 20, 12, 5, 5, -1);

    // address wrap at the top of the SRAM
    addr_q.push_back(10'h3FE); addr_q.push_back(10'h3FF);
    addr_q.push_back(10'h000); addr_q.push_back(10'h001);
    exp_q.push_back(18'h2AAAA); exp_q.push_back(18'h05555);
    exp_q.push_back(18'h0000E); exp_q.push_back(18'h10027);
    run_job(10'h3FE, 8'd4, 8'd1, 10'd0, 7, 4, -1, 0, -1);

    // zero-length rows: straight to DONE
    run_job(10'h000, 8'd0, 8'd3, 10'd6, 1, 0, -1, 0, -1);

    // reset in cycle 6 of the 12-word job: only words pushed in 3..6 appear
    for (int i = 0; i < 4; i++) exp_q.push_back(job1_exp[i]);
    base_addr = 10'h000; row_len = 8'd6; num_rows = 8'd2; row_pitch = 10'd6;
    clear_stats();
    c0 = cyc;
    start = 1'b1;
    for (int k = 1; k < 30; k++) begin
      next_cyc();
      if (k == 1) start = 1'b0;
      if (k == 6) rst = 1'b1;
      if (k == 7) begin
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_mem_rd_en", {31'h0, bus.mem_rd_en}, 32'h0);
        check("post_rst_mem_addr", {22'h0, bus.mem_addr}, 32'h0);
        check("post_rst_buf_write_en", {31'h0, bus.buf_write_en}, 32'h0);
        check("post_rst_buf_data", {14'h0, bus.buf_data}, 32'h0);
        check("post_rst_busy", {31'h0, busy}, 32'h0);
        check("post_rst_done", {31'h0, done}, 32'h0);
      end
    end
    check("rst_job_pushes", pushes, 4);
    check("rst_job_scoreboard_empty", exp_q.size(), 0);
    check("rst_job_no_done", done_rel, -1);

    // a fresh job after reset runs normally
    queue_job1();
    run_job(10'h000, 8'd6, 8'd2, 10'd6, 15, 12, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
